shift_add_mul: RTL and testbench

Parametrised sequential shift-add multiplier with an integrated controller. It computes an N×N product into a 2N-bit result and supports both unsigned and two's-complement signed operands. A start/done handshake drives the block, and it terminates early once the remaining multiplier bits are all zero. It replaces the separate multiplier datapath plus external controller pairing and drops into any control path that needs a multi-cycle multiply.

---
 rtl/shift_add_mul.sv | 75 +++++++
 tb/tb_shift_add_mul.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul.sv
// Sequential shift-add multiplier (N x N -> 2N) with start/done handshake,
// signed/unsigned operands and early exit once the multiplier is exhausted.
module shift_add_mul #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   dataA,
    input  logic [N-1:0]   dataB,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t         state;
    logic [2*N-1:0] A;
    logic [N-1:0]   B;
    logic           neg;

    // Magnitude of an operand; -2^(N-1) maps to 2^(N-1), still N unsigned bits.
    function automatic logic [N-1:0] mag(input logic [N-1:0] x, input logic sm);
        logic [N-1:0] r;
        r = x;
        if (sm && x[N-1])
            r = -x;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            A     <= '0;
            B     <= '0;
            P     <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        A     <= {{N{1'b0}}, mag(dataA, signed_mode)};
                        B     <= mag(dataB, signed_mode);
                        P     <= '0;
                        neg   <= signed_mode & (dataA[N-1] ^ dataB[N-1]);
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (B == '0) begin
                        state <= SIGN;
                    end else begin
                        if (B[0])
                            P <= P + A;
                        A <= A << 1;
                        B <= B >> 1;
                    end
                end
                SIGN: begin
                    if (neg)
                        P <= -P;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == CALC) || (state == SIGN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed and parametric checks for shift_add_mul: N=4 handshake/timing
// scenarios plus an N=8 instance compared against a reference product.
module tb_shift_add_mul;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start = 1'b0;
    logic       sm = 1'b0;
    logic [3:0] da = '0;
    logic [3:0] db = '0;
    logic       busy;
    logic       done;
    logic [7:0] p;

    logic        start8 = 1'b0;
    logic        sm8 = 1'b0;
    logic [7:0]  da8 = '0;
    logic [7:0]  db8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] p8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_add_mul #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
        .dataA(da), .dataB(db), .busy(busy), .done(done), .P(p)
    );

    shift_add_mul #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .dataA(da8), .dataB(db8), .busy(busy8), .done(done8), .P(p8)
    );

    // Called at posedge+1 with the DUT in IDLE; returns one cycle after done.
    // inject_at >= 0 raises start with other operands at that sample index.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [7:0] exp_p, input int exp_lat,
                        input int inject_at, input string name);
        int n;
        int nbusy;
        bit seen;
        bit busy_at_done;
        start = 1'b1; da = a; db = b; sm = s;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; nbusy = 0; seen = 1'b0; busy_at_done = 1'b0;
        while (!seen && n <= 20) begin
            if (n == inject_at) begin
                start = 1'b1; da = 4'h3; db = 4'h3; sm = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                busy_at_done = busy;
            end else begin
                if (busy) nbusy++;
                @(posedge clk); #1;
                n++;
            end
        end
        vectors++;
        if (!seen || n !== exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", name, n, seen, exp_lat);
        end
        vectors++;
        if (p !== exp_p) begin
            miscompares++;
            $display("FAIL %s product: got %h expected %h", name, p, exp_p);
        end
        vectors++;
        if (nbusy !== exp_lat || busy_at_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy: high %0d cycles (at done %0d) expected %0d (0)",
                     name, nbusy, busy_at_done, exp_lat);
        end
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done width: done=%b one cycle later, expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        vectors++;
        if (p !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset state: P=%h busy=%b done=%b expected 00 0 0", p, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        run4(4'd13, 4'd11, 1'b0, 8'h8F, 6, -1, "u13x11");
        run4(4'd15, 4'd15, 1'b0, 8'hE1, 6, -1, "u15x15");
        run4(4'd15, 4'd8,  1'b0, 8'h78, 6, -1, "u15x8");
        run4(4'd9,  4'd1,  1'b0, 8'h09, 3, -1, "u9x1");
    endtask

    task automatic test_signed();
        run4(4'hD, 4'h5, 1'b1, 8'hF1, 5, -1, "s-3x5");
        run4(4'h8, 4'h8, 1'b1, 8'h40, 6, -1, "s-8x-8");
        run4(4'hF, 4'hF, 1'b1, 8'h01, 3, -1, "s-1x-1");
        run4(4'h7, 4'h8, 1'b1, 8'hC8, 6, -1, "s7x-8");
        run4(4'h3, 4'hE, 1'b1, 8'hFA, 4, -1, "s3x-2");
    endtask

    task automatic test_early_term();
        run4(4'd7, 4'd0, 1'b0, 8'h00, 2, -1, "u7x0");
        run4(4'd7, 4'd0, 1'b1, 8'h00, 2, -1, "s7x0");
        run4(4'hB, 4'd0, 1'b1, 8'h00, 2, -1, "s-5x0");
    endtask

    task automatic test_handshake();
        run4(4'd13, 4'd11, 1'b0, 8'h8F, 6, 2, "hs_mid_start");
        run4(4'd13, 4'd11, 1'b0, 8'h8F, 6, 6, "hs_done_start");
        vectors++;
        if (busy !== 1'b0 || p !== 8'h8F) begin
            miscompares++;
            $display("FAIL hs_done_ignored: busy=%b P=%h expected 0 8f", busy, p);
        end
        run4(4'd2, 4'd3, 1'b0, 8'h06, 4, -1, "hs_after_done");
    endtask

    task automatic test_reset_midop();
        bit saw_done;
        start = 1'b1; da = 4'd15; db = 4'd15; sm = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (p !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midop async: P=%h busy=%b done=%b expected 00 0 0", p, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midop resume: busy/done seen after release, expected none");
        end
        run4(4'd15, 4'd15, 1'b0, 8'hE1, 6, -1, "reset_midop_fresh");
    endtask

    task automatic test_random8();
        logic [7:0]         a;
        logic [7:0]         b;
        logic [7:0]         mb;
        logic               s;
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic [15:0]        ex;
        int                 m;
        int                 n;
        bit                 seen;
        for (int r = 0; r < 1000; r++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (r < 4) b = (r < 2) ? 8'h00 : 8'h80;
            s = 1'($urandom_range(0, 1));
            if (s) begin
                sa = $signed(a); sb = $signed(b);
                ex = 16'(sa * sb);
                mb = b[7] ? 8'(-b) : b;
            end else begin
                ex = {8'h00, a} * {8'h00, b};
                mb = b;
            end
            m = 0;
            for (int i = 0; i < 8; i++)
                if (mb[i]) m = i + 1;
            start8 = 1'b1; da8 = a; db8 = b; sm8 = s;
            @(posedge clk); #1;
            start8 = 1'b0;
            n = 0; seen = 1'b0;
            while (!seen && n <= 20) begin
                if (done8) seen = 1'b1;
                else begin
                    @(posedge clk); #1;
                    n++;
                end
            end
            vectors++;
            if (p8 !== ex) begin
                miscompares++;
                $display("FAIL rand8 product %h*%h s=%b: got %h expected %h", a, b, s, p8, ex);
            end
            vectors++;
            if (!seen || n !== m + 2) begin
                miscompares++;
                $display("FAIL rand8 latency %h*%h s=%b: got %0d expected %0d", a, b, s, n, m + 2);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_early_term();
        test_handshake();
        test_reset_midop();
        test_random8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
